// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one aligned read per fetch_start and holds
// the returned word in an instruction register until decode takes it.
// Ports: clk/rst (sync, active-low); pc_in/fetch_start from control;
//   mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata to instruction memory;
//   flush aborts the current fetch; ir_out/ir_pc/ir_valid/ir_ready to decode;
//   pc_write, fetch_busy, fetch_err status back to control.
// Latency: request visible the cycle after fetch_start, ir_valid the cycle
// after mem_rvalid. Backpressure: mem_req/mem_addr hold until mem_gnt, and
// ir_* hold until ir_ready.
module instr_fetch_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] pc_in,
  input  logic                 fetch_start,
  output logic                 mem_req,
  output logic [BIT_WIDTH-1:0] mem_addr,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [31:0]          mem_rdata,
  input  logic                 flush,
  output logic [31:0]          ir_out,
  output logic [BIT_WIDTH-1:0] ir_pc,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic                 pc_write,
  output logic                 fetch_busy,
  output logic                 fetch_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] addr_q;
  logic [CW-1:0]        cnt;

  assign mem_addr   = addr_q;
  assign fetch_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      ir_out    <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      pc_write  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pc_write  <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // Flush outranks fetch_start even though it has nothing to cancel.
          if (fetch_start && !flush) begin
            if (pc_in[1:0] == 2'b00) begin
              addr_q  <= pc_in;
              mem_req <= 1'b1;
              state   <= S_REQ;
            end else begin
              fetch_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (flush || mem_gnt) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            // A granted request will still return data, which must be absorbed.
            if (flush) state <= mem_gnt ? S_DRAIN : S_IDLE;
            else       state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              state <= S_IDLE;
            end else begin
              ir_out   <= mem_rdata;
              ir_pc    <= addr_q;
              ir_valid <= 1'b1;
              pc_write <= 1'b1;
              state    <= S_HOLD;
            end
          end else if (cnt == CNT_LAST) begin
            // A flush landing on the last cycle is not reported as an error.
            fetch_err <= !flush;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (flush) state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= S_IDLE;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= S_IDLE;
            if (fetch_start) begin
              if (pc_in[1:0] == 2'b00) begin
                addr_q  <= pc_in;
                mem_req <= 1'b1;
                state   <= S_REQ;
              end else begin
                fetch_err <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          // Timeout here is silent: the fetch was already abandoned.
          if (mem_rvalid || cnt == CNT_LAST) state <= S_IDLE;
          else                               cnt   <= cnt + CW'(1);
        end
        default: begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table followed by
// hand-written grant-stall, drain and timeout sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_start;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        pc_write;
  logic        fetch_busy;
  logic        fetch_err;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.BIT_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .fetch_start(fetch_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_write(pc_write), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        fs;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        fl;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        irv;
    logic [31:0] ir;
    logic [31:0] irpc;
    logic        pcw;
    logic        busy;
    logic        err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic fs, input logic [31:0] pc,
                   input logic gnt, input logic rv, input logic [31:0] rd,
                   input logic fl, input logic rdy,
                   input logic req, input logic [31:0] addr, input logic irv,
                   input logic [31:0] ir, input logic [31:0] irpc,
                   input logic pcw, input logic busy, input logic err);
    vec_t t;
    t.i = '{rst: r, fs: fs, pc: pc, gnt: gnt, rv: rv, rd: rd, fl: fl, rdy: rdy};
    t.o = '{req: req, addr: addr, irv: irv, ir: ir, irpc: irpc,
            pcw: pcw, busy: busy, err: err};
    vecs.push_back(t);
  endtask

  task automatic apply(input in_t i);
    rst         = i.rst;
    fetch_start = i.fs;
    pc_in       = i.pc;
    mem_gnt     = i.gnt;
    mem_rvalid  = i.rv;
    mem_rdata   = i.rd;
    flush       = i.fl;
    ir_ready    = i.rdy;
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic fs, input logic [31:0] pc, input logic gnt,
                     input logic rv, input logic [31:0] rd, input logic fl,
                     input logic rdy);
    @(negedge clk);
    apply('{rst: 1'b1, fs: fs, pc: pc, gnt: gnt, rv: rv, rd: rd, fl: fl, rdy: rdy});
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    out_t act;
    apply('0);

    //  rst fs pc        gnt rv rdata         fl rdy | req addr      irv ir            irpc      pcw bsy err
    v(0, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 0); // reset
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 0);
    v(1, 1, 32'h40, 0, 0, 32'h0,         0, 0,   1, 32'h40, 0, 32'h0,         32'h00, 0, 1, 0); // REQ
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h40, 0, 32'h0,         32'h00, 0, 1, 0); // grant
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h40, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 0, 1, 32'h8C220004,  0, 0,   0, 32'h40, 1, 32'h8C220004,  32'h40, 1, 1, 0); // data
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h40, 1, 32'h8C220004,  32'h40, 0, 1, 0); // HOLD
    v(1, 0, 32'h00, 0, 1, 32'hDEADBEEF,  0, 0,   0, 32'h40, 1, 32'h8C220004,  32'h40, 0, 1, 0); // rvalid ignored
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 1,   0, 32'h40, 0, 32'h8C220004,  32'h40, 0, 0, 0); // consumed
    v(1, 1, 32'h42, 0, 0, 32'h0,         0, 0,   0, 32'h40, 0, 32'h8C220004,  32'h40, 0, 0, 1); // misaligned
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h40, 0, 32'h8C220004,  32'h40, 0, 0, 0);
    v(1, 1, 32'h80, 0, 0, 32'h0,         1, 0,   0, 32'h40, 0, 32'h8C220004,  32'h40, 0, 0, 0); // flush beats start
    v(1, 1, 32'h3C, 0, 0, 32'h0,         0, 0,   1, 32'h3C, 0, 32'h8C220004,  32'h40, 0, 1, 0);
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h3C, 0, 32'h8C220004,  32'h40, 0, 1, 0);
    v(1, 0, 32'h00, 0, 1, 32'h11112222,  0, 0,   0, 32'h3C, 1, 32'h11112222,  32'h3C, 1, 1, 0);
    v(1, 1, 32'h44, 0, 0, 32'h0,         0, 1,   1, 32'h44, 0, 32'h11112222,  32'h3C, 0, 1, 0); // back-to-back
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h44, 0, 32'h11112222,  32'h3C, 0, 1, 0); // WAIT
    v(0, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 0); // reset mid-fetch
    v(1, 0, 32'h00, 0, 1, 32'h55,        0, 0,   0, 32'h00, 0, 32'h0,         32'h00, 0, 0, 0); // stale rvalid
    v(1, 1, 32'h10, 0, 0, 32'h0,         0, 0,   1, 32'h10, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 0, 0, 32'h0,         1, 0,   0, 32'h10, 0, 32'h0,         32'h00, 0, 0, 0); // flush in REQ
    v(1, 1, 32'h20, 0, 0, 32'h0,         0, 0,   1, 32'h20, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 1, 0, 32'h0,         1, 0,   0, 32'h20, 0, 32'h0,         32'h00, 0, 1, 0); // flush+gnt: DRAIN
    v(1, 0, 32'h00, 0, 1, 32'h99,        0, 0,   0, 32'h20, 0, 32'h0,         32'h00, 0, 0, 0); // drained
    v(1, 1, 32'h24, 0, 0, 32'h0,         0, 0,   1, 32'h24, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h24, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 0, 1, 32'h77,        1, 0,   0, 32'h24, 0, 32'h0,         32'h00, 0, 0, 0); // flush+rvalid
    v(1, 1, 32'h28, 0, 0, 32'h0,         0, 0,   1, 32'h28, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h28, 0, 32'h0,         32'h00, 0, 1, 0);
    v(1, 0, 32'h00, 0, 1, 32'hCAFEF00D,  0, 0,   0, 32'h28, 1, 32'hCAFEF00D,  32'h28, 1, 1, 0);
    v(1, 1, 32'h30, 0, 0, 32'h0,         1, 1,   0, 32'h28, 0, 32'hCAFEF00D,  32'h28, 0, 0, 0); // flush in HOLD
    v(1, 1, 32'h2C, 0, 0, 32'h0,         0, 0,   1, 32'h2C, 0, 32'hCAFEF00D,  32'h28, 0, 1, 0);
    v(1, 0, 32'h00, 1, 0, 32'h0,         0, 0,   0, 32'h2C, 0, 32'hCAFEF00D,  32'h28, 0, 1, 0);
    v(1, 0, 32'h00, 0, 1, 32'h0BADF00D,  0, 0,   0, 32'h2C, 1, 32'h0BADF00D,  32'h2C, 1, 1, 0);
    v(1, 1, 32'h31, 0, 0, 32'h0,         0, 1,   0, 32'h2C, 0, 32'h0BADF00D,  32'h2C, 0, 0, 1); // b2b misaligned
    v(1, 0, 32'h00, 0, 0, 32'h0,         0, 0,   0, 32'h2C, 0, 32'h0BADF00D,  32'h2C, 0, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      apply(vecs[n].i);
      @(posedge clk);
      #1;
      act = '{req: mem_req, addr: mem_addr, irv: ir_valid, ir: ir_out, irpc: ir_pc,
              pcw: pc_write, busy: fetch_busy, err: fetch_err};
      checks++;
      if (act !== vecs[n].o) begin
        errors++;
        $display("FAIL vec%0d: got %h expected %h", n, act, vecs[n].o);
      end
    end

    // Grant stall: request and address must hold until the grant.
    cyc(1, 32'h40, 0, 0, 32'h0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
      chk("stall_req", 64'(mem_req), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'h40);
    end
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 0);
    chk("stall_gnt_req", 64'(mem_req), 64'd0);
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 0);
    chk("stall_extra_gnt", {mem_req, fetch_busy}, 64'b01);
    cyc(0, 32'h0, 0, 1, 32'h12345678, 0, 0);
    chk("stall_data", {ir_valid, pc_write, ir_out}, {2'b11, 32'h12345678});
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 1);
    chk("stall_consume", {ir_valid, fetch_busy}, 64'b00);

    // Flush in WAIT, response three cycles later lands in DRAIN.
    cyc(1, 32'h50, 0, 0, 32'h0, 0, 0);
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 0);
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 0);
    chk("drain_busy0", {mem_req, fetch_busy}, 64'b01);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
      chk("drain_wait", {fetch_busy, ir_valid}, 64'b10);
    end
    cyc(0, 32'h0, 0, 1, 32'hAAAA5555, 0, 0);
    chk("drain_absorb", {fetch_busy, ir_valid, pc_write, ir_out}, {3'b000, 32'h12345678});

    // Timeout: error strobe exactly 16 cycles after the grant edge.
    cyc(1, 32'h60, 0, 0, 32'h0, 0, 0);
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
      chk($sformatf("timeout_err_c%0d", k), {fetch_err, fetch_busy},
          (k == 16) ? 64'b10 : 64'b01);
    end
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 0);
    chk("timeout_err_clear", {fetch_err, ir_valid}, 64'b00);
    cyc(0, 32'h0, 0, 1, 32'hFFFF0000, 0, 0);
    chk("timeout_late_rvalid", {ir_valid, pc_write, fetch_busy, ir_out},
        {3'b000, 32'h12345678});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, which sets the width of the address and program counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, which sets the maximum number of cycles spent in WAIT before abort.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port pc_in, input, BIT_WIDTH bits: the current PC from the PC register.
REQ-006 The block SHALL have port fetch_start, input, 1 bit: fetch request from the control FSM.
REQ-007 The block SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port mem_addr, output, BIT_WIDTH bits: read address.
REQ-009 The block SHALL have port mem_gnt, input, 1 bit: memory accepts the request.
REQ-010 The block SHALL have port mem_rvalid, input, 1 bit: read data valid.
REQ-011 The block SHALL have port mem_rdata, input, 32 bits: read data.
REQ-012 The block SHALL have port flush, input, 1 bit: discard the in-flight fetch or held instruction.
REQ-013 The block SHALL have port ir_out, output, 32 bits: instruction register.
REQ-014 The block SHALL have port ir_pc, output, BIT_WIDTH bits: the address ir_out was fetched from.
REQ-015 The block SHALL have port ir_valid, output, 1 bit: ir_out holds a valid instruction.
REQ-016 The block SHALL have port ir_ready, input, 1 bit: decode consumes ir_out.
REQ-017 The block SHALL have port pc_write, output, 1 bit: one-cycle strobe telling the PC register to advance.
REQ-018 The block SHALL have port fetch_busy, output, 1 bit: high when the state is not IDLE.
REQ-019 The block SHALL have port fetch_err, output, 1 bit: one-cycle error strobe.

Function
REQ-020 The state machine SHALL have states IDLE, REQ, WAIT, HOLD and DRAIN.
REQ-021 In IDLE, on fetch_start with pc_in[1:0]==0, the block SHALL latch pc_in into addr_q and go to REQ.
REQ-022 In IDLE, on fetch_start with pc_in[1:0]!=0, the block SHALL pulse fetch_err for the next cycle, stay in IDLE, and issue no request.
REQ-023 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal addr_q, both held stable until mem_gnt.
REQ-024 In every state other than REQ, mem_req SHALL be 0.
REQ-025 In REQ, on mem_gnt, the block SHALL go to WAIT and clear the timeout counter.
REQ-026 mem_rvalid SHALL be sampled only in WAIT and DRAIN; the earliest accepted response is the cycle after grant.
REQ-027 mem_rvalid SHALL be ignored in IDLE, REQ and HOLD.
REQ-028 In WAIT, on mem_rvalid, the block SHALL capture ir_out<=mem_rdata and ir_pc<=addr_q.
REQ-029 In WAIT, on mem_rvalid, the block SHALL set ir_valid<=1 and pc_write<=1 for exactly one cycle, then go to HOLD.
REQ-030 In WAIT, the timeout counter SHALL increment each cycle without mem_rvalid.
REQ-031 When the timeout counter reaches TIMEOUT-1 without mem_rvalid, the block SHALL pulse fetch_err, go to IDLE, and leave ir_valid at 0.
REQ-032 In HOLD, ir_valid SHALL stay 1 and ir_out and ir_pc SHALL stay stable until ir_ready.
REQ-033 In HOLD, on ir_ready without fetch_start, the block SHALL clear ir_valid and go to IDLE.
REQ-034 In HOLD, on ir_ready with fetch_start (back-to-back fetch), the block SHALL clear ir_valid, apply the same pc_in check as in IDLE, and go directly to REQ or pulse fetch_err.
REQ-035 Flush in IDLE SHALL have no effect.
REQ-036 Flush in REQ without mem_gnt SHALL drop mem_req the next cycle and go to IDLE.
REQ-037 Flush in REQ together with mem_gnt SHALL go to DRAIN.
REQ-038 Flush in WAIT without mem_rvalid SHALL go to DRAIN.
REQ-039 Flush in WAIT together with mem_rvalid SHALL discard the data, produce no pc_write and no ir_valid, and go to IDLE.
REQ-040 Flush in HOLD SHALL clear ir_valid and go to IDLE; flush has priority over ir_ready.
REQ-041 In DRAIN, the block SHALL discard the first mem_rvalid, with no ir or pc_write update, and then go to IDLE.
REQ-042 In DRAIN, the timeout SHALL apply as in WAIT, but without asserting fetch_err.
REQ-043 fetch_start SHALL be ignored in REQ, WAIT and DRAIN.
REQ-044 Flush SHALL have priority over fetch_start in all states.

Reset
REQ-045 When rst==0 at a clock edge, the block SHALL go to IDLE and clear mem_req, ir_valid, pc_write, fetch_err, ir_out, ir_pc, addr_q and the counter to 0.
REQ-046 Reset SHALL override every other input, including when it occurs mid-transaction.
REQ-047 After reset, any response from an outstanding request SHALL be ignored, because the block is in IDLE.

Verification
REQ-048 Basic fetch: fetch_start with pc_in=0x0000_0040, mem_gnt in cycle 1, mem_rvalid with 0x8C22_0004 two cycles later, then ir_ready -> ir_out=0x8C220004, ir_pc=0x40, single pc_write pulse, ir_valid held until ir_ready.
REQ-049 Grant stall: mem_gnt low for 5 cycles -> mem_req and mem_addr=0x40 stable for all 5 cycles; exactly one grant accepted.
REQ-050 Misaligned fetch: fetch_start with pc_in=0x0000_0042 -> fetch_err=1 for one cycle, mem_req never 1, fetch_busy stays 0.
REQ-051 Flush in WAIT, then mem_rvalid 3 cycles later -> DRAIN absorbs the data, ir_valid stays 0, no pc_write, IDLE after the response.
REQ-052 Timeout: with TIMEOUT=16 and no mem_rvalid -> fetch_err pulses 16 cycles after grant; a later rvalid in IDLE is ignored.
REQ-053 Back-to-back and reset: ir_ready with fetch_start and pc_in=0x44 in HOLD -> mem_req=1 the next cycle with mem_addr=0x44; then rst=0 in WAIT -> all outputs 0 the next cycle.
